// File: rtl/wb_arb5_if.sv
// wb_arb5_if: write-port arbitration bus between the five result producers
// and the register-file write-back arbiter.
//   req[4:0]        producer write requests (level)
//   waddr0..waddr4  destination register of each producer
//   stall           pipeline stall, suppresses grants
//   gnt[4:0]        registered one-hot grant
//   s[2:0]          write-data mux select (binary index of grantee)
//   we              register-file write enable
//   waddr           register-file write address
// master: producer/pipeline side; slave: arbiter side.
interface wb_arb5_if #(parameter int AW = 4);
  logic [4:0]    req;
  logic [AW-1:0] waddr0;
  logic [AW-1:0] waddr1;
  logic [AW-1:0] waddr2;
  logic [AW-1:0] waddr3;
  logic [AW-1:0] waddr4;
  logic          stall;
  logic [4:0]    gnt;
  logic [2:0]    s;
  logic          we;
  logic [AW-1:0] waddr;

  modport master (
    output req, waddr0, waddr1, waddr2, waddr3, waddr4, stall,
    input  gnt, s, we, waddr
  );

  modport slave (
    input  req, waddr0, waddr1, waddr2, waddr3, waddr4, stall,
    output gnt, s, we, waddr
  );
endinterface

// File: rtl/wb_arb5.sv
// wb_arb5: round-robin scheduler for the 16-bit register-file write port.
// Five producers (ALU, load, immediate, PC link, I/O) share one write port;
// the block picks one requester per cycle and drives the 5:1 data-mux
// select, write enable and write address. All outputs are registered.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    wb_arb5_if slave modport (req/waddrN/stall in, gnt/s/we/waddr out)
module wb_arb5 #(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_arb5_if.slave    bus
);

  logic [2:0]    ptr;
  logic [4:0]    elig;
  logic [2:0]    base;
  logic [3:0]    idx;
  logic          found;
  logic [2:0]    win;
  logic [2:0]    ptr_nxt;
  logic [AW-1:0] waddr_sel;

  always_comb begin
    // The current grantee is masked for one cycle so a held request
    // cannot produce two writes from one grant.
    elig  = bus.req & ~bus.gnt;
    // Pointer values 5..7 are unreachable; fold them to 0 defensively.
    base  = (ptr > 3'd4) ? 3'd0 : ptr;
    found = 1'b0;
    win   = 3'd0;
    idx   = 4'd0;
    for (int k = 0; k < 5; k++) begin
      idx = {1'b0, base} + 4'(k);
      if (idx >= 4'd5) idx = idx - 4'd5;
      if (!found && elig[idx[2:0]]) begin
        found = 1'b1;
        win   = idx[2:0];
      end
    end
    ptr_nxt = (win == 3'd4) ? 3'd0 : win + 3'd1;
    case (win)
      3'd0:    waddr_sel = bus.waddr0;
      3'd1:    waddr_sel = bus.waddr1;
      3'd2:    waddr_sel = bus.waddr2;
      3'd3:    waddr_sel = bus.waddr3;
      3'd4:    waddr_sel = bus.waddr4;
      default: waddr_sel = bus.waddr0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= 3'd0;
      bus.gnt   <= 5'd0;
      bus.s     <= 3'd0;
      bus.we    <= 1'b0;
      bus.waddr <= '0;
    end else if (bus.stall || !found) begin
      // S, WADDR and PTR hold so the mux stays quiet while idle.
      bus.gnt <= 5'd0;
      bus.we  <= 1'b0;
    end else begin
      ptr       <= ptr_nxt;
      bus.gnt   <= 5'd1 << win;
      bus.s     <= win;
      bus.we    <= 1'b1;
      bus.waddr <= waddr_sel;
    end
  end

endmodule

// File: tb/tb_wb_arb5.sv
module tb_wb_arb5;
  logic clk;
  logic rst_n;

  wb_arb5_if #(.AW(4)) bus ();

  wb_arb5 #(.AW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [4:0] gnt;
    logic [2:0] s;
    logic [3:0] waddr;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic push_grant(input int idx, input logic [3:0] wa);
    exp_t x;
    x.gnt   = 5'd1 << idx;
    x.s     = 3'(idx);
    x.waddr = wa;
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every written cycle must match the next expectation.
  always @(negedge clk) begin
    if (rst_n && bus.we) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL grant_unexpected: got gnt=%b s=%0d waddr=%0h, expected no write (t=%0t)",
                 bus.gnt, bus.s, bus.waddr, $time);
      end else begin
        e = exp_q.pop_front();
        if (bus.gnt !== e.gnt || bus.s !== e.s || bus.waddr !== e.waddr) begin
          n_fail++;
          $display("FAIL grant_seq: got gnt=%b s=%0d waddr=%0h, expected gnt=%b s=%0d waddr=%0h (t=%0t)",
                   bus.gnt, bus.s, bus.waddr, e.gnt, e.s, e.waddr, $time);
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    bus.req    = 5'b11111;
    bus.stall  = 1'b0;
    bus.waddr0 = 4'd8;
    bus.waddr1 = 4'd9;
    bus.waddr2 = 4'd10;
    bus.waddr3 = 4'd11;
    bus.waddr4 = 4'd12;

    // Reset held across an edge with all requests up.
    #12;
    chk("rst_gnt",   16'(bus.gnt),   16'd0);
    chk("rst_we",    16'(bus.we),    16'd0);
    chk("rst_s",     16'(bus.s),     16'd0);
    chk("rst_waddr", 16'(bus.waddr), 16'd0);
    rst_n = 1'b1;

    // All held: 0,1,2,3,4,0 with WADDR 8..12,8 and WE every cycle.
    for (int i = 0; i < 6; i++) begin
      push_grant(i % 5, 4'(8 + (i % 5)));
      step();
      chk("all_we", 16'(bus.we), 16'd1);
    end
    bus.req = 5'b00000;
    step();
    chk("idle_gnt",   16'(bus.gnt),   16'd0);
    chk("idle_s",     16'(bus.s),     16'd0);
    chk("idle_waddr", 16'(bus.waddr), 16'd8);

    // Lone requester 2: granted every other cycle, S stays 2.
    bus.waddr2 = 4'hA;
    bus.req    = 5'b00100;
    push_grant(2, 4'hA);
    push_grant(2, 4'hA);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("lone_we", 16'(bus.we), (i % 2 == 0) ? 16'd1 : 16'd0);
      chk("lone_s",  16'(bus.s),  16'd2);
    end
    bus.req = 5'b00000;

    // PTR=3 now: 3 beats 1, then search wraps from 4 to 1.
    bus.req = 5'b01010;
    push_grant(3, 4'd11);
    push_grant(1, 4'd9);
    step();
    chk("wrap_first", 16'(bus.gnt), 16'b01000);
    bus.req = 5'b00010;
    step();
    chk("wrap_second", 16'(bus.gnt), 16'b00010);
    bus.req = 5'b00000;
    step();

    // Stall for 3 cycles with REQ[4] up.
    bus.stall = 1'b1;
    bus.req   = 5'b10000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_gnt",   16'(bus.gnt),   16'd0);
      chk("stall_we",    16'(bus.we),    16'd0);
      chk("stall_s",     16'(bus.s),     16'd1);
      chk("stall_waddr", 16'(bus.waddr), 16'd9);
    end
    bus.stall = 1'b0;
    push_grant(4, 4'd12);
    step();
    chk("unstall_s", 16'(bus.s), 16'd4);
    bus.req = 5'b00000;

    // Async reset in the middle of a grant to 3.
    bus.req = 5'b01000;
    push_grant(3, 4'd11);
    step();
    chk("pre_rst_gnt", 16'(bus.gnt), 16'b01000);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt",   16'(bus.gnt),   16'd0);
    chk("arst_we",    16'(bus.we),    16'd0);
    chk("arst_s",     16'(bus.s),     16'd0);
    chk("arst_waddr", 16'(bus.waddr), 16'd0);
    bus.req = 5'b01001;
    #1;
    rst_n = 1'b1;
    push_grant(0, 4'd8);
    step();
    chk("post_rst_gnt", 16'(bus.gnt), 16'b00001);
    bus.req = 5'b00000;
    step();
    step();
    step();

    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
